// File: rtl/xm23_pkg.sv
// Shared XM-23 definitions: opcode numbering, major-group prefixes and the
// decoded field bundle exchanged between the instruction decoder and encoder.
package xm23_pkg;

    localparam logic [6:0] OP_BL     = 7'd0;
    localparam logic [6:0] OP_BEQ    = 7'd1;
    localparam logic [6:0] OP_BNE    = 7'd2;
    localparam logic [6:0] OP_BC     = 7'd3;
    localparam logic [6:0] OP_BNC    = 7'd4;
    localparam logic [6:0] OP_BN     = 7'd5;
    localparam logic [6:0] OP_BGE    = 7'd6;
    localparam logic [6:0] OP_BLT    = 7'd7;
    localparam logic [6:0] OP_BRA    = 7'd8;
    localparam logic [6:0] OP_ADD    = 7'd9;
    localparam logic [6:0] OP_ADDC   = 7'd10;
    localparam logic [6:0] OP_SUB    = 7'd11;
    localparam logic [6:0] OP_SUBC   = 7'd12;
    localparam logic [6:0] OP_DADD   = 7'd13;
    localparam logic [6:0] OP_CMP    = 7'd14;
    localparam logic [6:0] OP_XOR    = 7'd15;
    localparam logic [6:0] OP_AND    = 7'd16;
    localparam logic [6:0] OP_OR     = 7'd17;
    localparam logic [6:0] OP_BIT    = 7'd18;
    localparam logic [6:0] OP_BIC    = 7'd19;
    localparam logic [6:0] OP_BIS    = 7'd20;
    localparam logic [6:0] OP_MOV    = 7'd21;
    localparam logic [6:0] OP_SRA    = 7'd22;
    localparam logic [6:0] OP_RRC    = 7'd23;
    localparam logic [6:0] OP_COMP   = 7'd24;
    localparam logic [6:0] OP_SWAP   = 7'd25;
    localparam logic [6:0] OP_SWPB   = 7'd26;
    localparam logic [6:0] OP_SXT    = 7'd27;
    localparam logic [6:0] OP_SETPRI = 7'd28;
    localparam logic [6:0] OP_SVC    = 7'd29;
    localparam logic [6:0] OP_SETCC  = 7'd30;
    localparam logic [6:0] OP_CLRCC  = 7'd31;
    localparam logic [6:0] OP_CEX    = 7'd32;
    localparam logic [6:0] OP_LD     = 7'd33;
    localparam logic [6:0] OP_ST     = 7'd34;
    localparam logic [6:0] OP_MOVL   = 7'd35;
    localparam logic [6:0] OP_MOVLZ  = 7'd36;
    localparam logic [6:0] OP_MOVLS  = 7'd37;
    localparam logic [6:0] OP_MOVH   = 7'd38;
    localparam logic [6:0] OP_LDR    = 7'd39;
    localparam logic [6:0] OP_STR    = 7'd40;
    localparam logic [6:0] OP_BRKPT  = 7'd41;

    localparam logic [2:0] GRP_BL   = 3'b000;
    localparam logic [2:0] GRP_BR   = 3'b001;
    localparam logic [2:0] GRP_ALU  = 3'b010;
    localparam logic [2:0] GRP_MOVX = 3'b011;

    // Common prefix of the single-register / special-purpose subgroup.
    localparam logic [5:0] PFX_SPECIAL = 6'b010011;
    localparam logic [5:0] PFX_CEX     = 6'b010100;
    localparam logic [4:0] PFX_LDST    = 5'b01011;
    localparam logic [15:0] WORD_BRKPT = 16'h5400;

    typedef struct packed {
        logic [6:0]  op;
        logic [12:0] off;
        logic [3:0]  c;
        logic [2:0]  t;
        logic [2:0]  f;
        logic [2:0]  pr;
        logic [3:0]  sa;
        logic [4:0]  pswb;
        logic [2:0]  dst;
        logic [2:0]  srccon;
        logic        wb;
        logic        rc;
        logic        prpo;
        logic        dec;
        logic        inc;
        logic [7:0]  imbyte;
    } xm23_fields_t;

    // True when off, read as signed, is representable in a width-bit field.
    function automatic logic off_fits(input logic [12:0] off, input int width);
        logic signed [12:0] hi;
        hi = $signed(off) >>> (width - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/encoder_fifo.sv
// Small synchronous FIFO holding encoded {instruction, address} entries.
// The head reads as zero while the FIFO is empty.
module encoder_fifo
    import xm23_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign count   = cnt;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage is deliberately left unreset; stale entries are never
    // visible because reads are gated by empty and the pointers do reset.
    always_ff @(posedge Clock) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs XM-23 field bundles into 16-bit words tagged with a byte address and
// queues them. Define ENC_RANGE_CHECK_EN to fault on out-of-range offsets.
module instruction_encoder
    import xm23_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [6:0]  OP,
    input  logic [12:0] OFF,
    input  logic [3:0]  C,
    input  logic [2:0]  T,
    input  logic [2:0]  F,
    input  logic [2:0]  PR,
    input  logic [3:0]  SA,
    input  logic [4:0]  PSWb,
    input  logic [2:0]  DST,
    input  logic [2:0]  SRCCON,
    input  logic        WB,
    input  logic        RC,
    input  logic        PRPO,
    input  logic        DEC,
    input  logic        INC,
    input  logic [7:0]  ImByte,
    input  logic        OrgValid,
    input  logic [15:0] OrgAddr,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [15:0] Instr,
    output logic [15:0] Addr,
    output logic        FLTo
);

    localparam int CW = $clog2(DEPTH) + 1;

    xm23_fields_t  fld;
    logic [15:0]   word;
    logic          op_bad;
    logic          fault;
    logic          accept;
    logic          push;
    logic          pop;
    logic [15:0]   addr;
    logic [15:0]   tag_addr;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign fld = '{op: OP, off: OFF, c: C, t: T, f: F, pr: PR, sa: SA, pswb: PSWb,
                   dst: DST, srccon: SRCCON, wb: WB, rc: RC, prpo: PRPO,
                   dec: DEC, inc: INC, imbyte: ImByte};

    // NOTE: word takes a default before the case so no path infers a latch.
    always_comb begin
        word = '0;
        case (fld.op) inside
            OP_BL:             word = {GRP_BL, fld.off};
            [OP_BEQ:OP_BRA]:   word = {GRP_BR, 3'(fld.op - OP_BEQ), fld.off[9:0]};
            [OP_ADD:OP_BIS]:   word = {GRP_ALU, 1'b0, 4'(fld.op - OP_ADD), fld.rc, fld.wb,
                                       fld.srccon, fld.dst};
            OP_MOV:            word = {PFX_SPECIAL, 3'b000, fld.wb, fld.srccon, fld.dst};
            [OP_SRA:OP_COMP]:  word = {PFX_SPECIAL, 3'b001, fld.wb, 3'(fld.op - OP_SRA), fld.dst};
            OP_SWAP:           word = {PFX_SPECIAL, 3'b010, 1'b0, fld.srccon, fld.dst};
            [OP_SWPB:OP_SETPRI]:
                               word = {PFX_SPECIAL, 3'b010, 1'b1, 3'(fld.op - OP_SWPB),
                                       (fld.op == OP_SETPRI) ? fld.pr : fld.dst};
            OP_SVC:            word = {PFX_SPECIAL, 3'b011, 3'b000, fld.sa};
            [OP_SETCC:OP_CLRCC]:
                               word = {PFX_SPECIAL, 3'b100, 1'b0, 1'(fld.op - OP_SETCC), fld.pswb};
            OP_CEX:            word = {PFX_CEX, fld.c, fld.t, fld.f};
            [OP_LD:OP_ST]:     word = {PFX_LDST, 1'(fld.op - OP_LD), fld.prpo, fld.dec, fld.inc,
                                       fld.wb, fld.srccon, fld.dst};
            [OP_MOVL:OP_MOVH]: word = {GRP_MOVX, 2'(fld.op - OP_MOVL), fld.imbyte, fld.dst};
            [OP_LDR:OP_STR]:   word = {1'b1, 1'(fld.op - OP_LDR), fld.off[6:0], fld.wb,
                                       fld.srccon, fld.dst};
            OP_BRKPT:          word = WORD_BRKPT;
            default:           word = '0;
        endcase
    end

    assign op_bad = (fld.op > OP_BRKPT);

`ifdef ENC_RANGE_CHECK_EN
    logic range_ok;
    always_comb begin
        range_ok = 1'b1;
        if (fld.op >= OP_BEQ && fld.op <= OP_BRA)
            range_ok = off_fits(fld.off, 10);
        else if (fld.op == OP_LDR || fld.op == OP_STR)
            range_ok = off_fits(fld.off, 7);
    end
    assign fault = op_bad | ~range_ok;
`else
    assign fault = op_bad;
`endif

    assign InReady  = (fifo_count != CW'(DEPTH));
    assign OutValid = ~fifo_empty;
    assign accept   = InValid & InReady;
    assign push     = accept & ~fault;
    assign pop      = OutValid & OutReady;

    // An org load applies before a same-cycle accept, so it tags that word.
    assign tag_addr = OrgValid ? (OrgAddr & 16'hFFFE) : addr;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            addr <= BASE_ADDR & 16'hFFFE;
            FLTo <= 1'b0;
        end else begin
            addr <= push ? tag_addr + 16'd2 : tag_addr;
            FLTo <= accept & fault;
        end
    end

    encoder_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .Clock(Clock),
        .Reset(Reset),
        .push (push),
        .pop  (pop),
        .din  ({word, tag_addr}),
        .dout ({Instr, Addr}),
        .empty(fifo_empty),
        .count(fifo_count)
    );

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed scenarios plus randomized traffic
// compared against an arithmetic encoding model and a queue-based FIFO model.
module tb_instruction_encoder;

    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'h0000;

    logic        Clock;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [6:0]  OP;
    logic [12:0] OFF;
    logic [3:0]  C;
    logic [2:0]  T;
    logic [2:0]  F;
    logic [2:0]  PR;
    logic [3:0]  SA;
    logic [4:0]  PSWb;
    logic [2:0]  DST;
    logic [2:0]  SRCCON;
    logic        WB;
    logic        RC;
    logic        PRPO;
    logic        DEC;
    logic        INC;
    logic [7:0]  ImByte;
    logic        OrgValid;
    logic [15:0] OrgAddr;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] Instr;
    logic [15:0] Addr;
    logic        FLTo;

    instruction_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .OP(OP), .OFF(OFF), .C(C), .T(T), .F(F), .PR(PR), .SA(SA), .PSWb(PSWb),
        .DST(DST), .SRCCON(SRCCON), .WB(WB), .RC(RC), .PRPO(PRPO), .DEC(DEC),
        .INC(INC), .ImByte(ImByte), .OrgValid(OrgValid), .OrgAddr(OrgAddr),
        .OutValid(OutValid), .OutReady(OutReady), .Instr(Instr), .Addr(Addr),
        .FLTo(FLTo)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] addr;
    } entry_t;

    entry_t      q[$];
    logic [15:0] m_addr;
    logic        m_flt;
    int          total;
    int          bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Encoding written as field weights (powers of two) over plain integers.
    function automatic logic [15:0] ref_word();
        int op, off, d, s, w;
        op  = int'(OP);
        off = int'(OFF);
        d   = int'(DST);
        s   = int'(SRCCON) * 8;
        w   = 0;
        if (op == 0)       w = off;
        else if (op <= 8)  w = 'h2000 + (op - 1) * 1024 + off % 1024;
        else if (op <= 20) w = 'h4000 + (op - 9) * 256 + int'(RC) * 128 + int'(WB) * 64 + s + d;
        else if (op == 21) w = 'h4C00 + int'(WB) * 64 + s + d;
        else if (op <= 24) w = 'h4C80 + int'(WB) * 64 + (op - 22) * 8 + d;
        else if (op == 25) w = 'h4D00 + s + d;
        else if (op <= 28) w = 'h4D40 + (op - 26) * 8 + ((op == 28) ? int'(PR) : d);
        else if (op == 29) w = 'h4D80 + int'(SA);
        else if (op <= 31) w = 'h4E00 + (op - 30) * 32 + int'(PSWb);
        else if (op == 32) w = 'h5000 + int'(C) * 64 + int'(T) * 8 + int'(F);
        else if (op <= 34) w = 'h5800 + (op - 33) * 1024 + int'(PRPO) * 512 + int'(DEC) * 256
                               + int'(INC) * 128 + int'(WB) * 64 + s + d;
        else if (op <= 38) w = 'h6000 + (op - 35) * 2048 + int'(ImByte) * 8 + d;
        else if (op <= 40) w = 'h8000 + (op - 39) * 16384 + (off % 128) * 128 + int'(WB) * 64 + s + d;
        else               w = 'h5400;
        return 16'(w);
    endfunction

    function automatic bit ref_fault();
        int op;
        op = int'(OP);
        if (op > 41) return 1'b1;
`ifdef ENC_RANGE_CHECK_EN
        begin
            int sv;
            sv = (int'(OFF) >= 4096) ? int'(OFF) - 8192 : int'(OFF);
            if (op >= 1 && op <= 8 && (sv < -512 || sv > 511)) return 1'b1;
            if ((op == 39 || op == 40) && (sv < -64 || sv > 63)) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic compare_outputs();
        check("out_valid", OutValid, (q.size() > 0));
        check("in_ready", InReady, (q.size() < DEPTH));
        check("flt", FLTo, m_flt);
        if (q.size() > 0) begin
            check("head_instr", Instr, q[0].instr);
            check("head_addr", Addr, q[0].addr);
        end else begin
            check("empty_instr", Instr, 0);
            check("empty_addr", Addr, 0);
        end
    endtask

    // Advance the model by one cycle from the current inputs, clock the DUT, compare.
    task automatic tick();
        bit          acc;
        bit          pop;
        logic [15:0] base;
        pop  = (q.size() > 0) && OutReady;
        acc  = InValid && (q.size() < DEPTH);
        base = OrgValid ? {OrgAddr[15:1], 1'b0} : m_addr;
        m_flt = 1'b0;
        if (pop) void'(q.pop_front());
        if (acc) begin
            if (ref_fault()) begin
                m_flt = 1'b1;
            end else begin
                q.push_back('{instr: ref_word(), addr: base});
                base = base + 16'd2;
            end
        end
        m_addr = base;
        @(posedge Clock);
        #1;
        compare_outputs();
    endtask

    task automatic clear_inputs();
        InValid = 0; OP = 0; OFF = 0; C = 0; T = 0; F = 0; PR = 0; SA = 0; PSWb = 0;
        DST = 0; SRCCON = 0; WB = 0; RC = 0; PRPO = 0; DEC = 0; INC = 0; ImByte = 0;
        OrgValid = 0; OrgAddr = 0;
    endtask

    task automatic rand_fields();
        OP     = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(42, 127)) : 7'($urandom_range(0, 41));
        OFF    = $urandom_range(0, 1) ? 13'($urandom) :
                 ($urandom_range(0, 1) ? 13'($urandom_range(0, 63)) : 13'(8192 - $urandom_range(1, 64)));
        C      = 4'($urandom); T = 3'($urandom); F = 3'($urandom); PR = 3'($urandom);
        SA     = 4'($urandom); PSWb = 5'($urandom); DST = 3'($urandom); SRCCON = 3'($urandom);
        WB     = 1'($urandom); RC = 1'($urandom); PRPO = 1'($urandom);
        DEC    = 1'($urandom); INC = 1'($urandom); ImByte = 8'($urandom);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic do_reset();
        Reset = 1'b1;
        #1;
        q.delete();
        m_addr = BASE;
        m_flt  = 1'b0;
        check("rst_out_valid", OutValid, 0);
        check("rst_in_ready", InReady, 1);
        check("rst_instr", Instr, 0);
        check("rst_addr", Addr, 0);
        check("rst_flt", FLTo, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    task automatic set_add();
        OP = 7'd9; RC = 0; WB = 0; SRCCON = 3'd3; DST = 3'd2;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        OutReady = 0;
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        do_reset();

        // ADD right after reset
        set_add();
        InValid = 1; tick(); InValid = 0;
        check("add_valid", OutValid, 1);
        check("add_instr", Instr, 16'h401A);
        check("add_addr", Addr, 16'h0000);

        // MOVL then BREAKPOINT, head held under backpressure
        do_reset();
        OutReady = 0;
        OP = 7'd35; ImByte = 8'hAB; DST = 3'd5;
        InValid = 1; tick();
        OP = 7'd41; tick(); InValid = 0;
        check("movl_instr", Instr, 16'h655D);
        check("movl_addr", Addr, 16'h0000);
        OutReady = 1; tick();
        check("brk_instr", Instr, 16'h5400);
        check("brk_addr", Addr, 16'h0002);
        tick();
        check("brk_drained", OutValid, 0);

        // Invalid opcode: one-cycle fault pulse, no push, address kept
        do_reset();
        OP = 7'd42; InValid = 1; tick(); InValid = 0;
        check("bad_op_flt", FLTo, 1);
        check("bad_op_nopush", OutValid, 0);
        tick();
        check("bad_op_flt_gone", FLTo, 0);
        set_add();
        InValid = 1; tick(); InValid = 0;
        check("bad_op_next_addr", Addr, 16'h0000);
        tick();

        // Backpressure: fill, attempt an accept with a same-cycle pop, drain
        do_reset();
        OutReady = 0;
        InValid  = 1;
        for (int i = 0; i < DEPTH; i++) begin
            rand_fields();
            OP = 7'(i * 10);
            tick();
        end
        check("bp_ready_low", InReady, 0);
        OutReady = 1;
        rand_fields();
        OP = 7'd9;
        tick();
        InValid = 0;
        check("bp_no_accept_addr", Addr, 16'h0002);
        for (int i = 0; i < 8 && q.size() > 0; i++) tick();
        check("bp_ready_back", InReady, 1);
        check("bp_empty", OutValid, 0);

        // Org with simultaneous accept, then wrap past 0xFFFE
        do_reset();
        OutReady = 0;
        set_add();
        OrgValid = 1; OrgAddr = 16'h0101; InValid = 1; tick();
        check("org_addr", Addr, 16'h0100);
        OrgAddr = 16'hFFFE; tick();
        OrgValid = 0; tick(); InValid = 0;
        OutReady = 1; tick();
        check("wrap_addr_hi", Addr, 16'hFFFE);
        tick();
        check("wrap_addr_lo", Addr, 16'h0000);
        tick();

        // Branch offset outside its 10-bit field
        do_reset();
        OP = 7'd1; OFF = 13'h0400; InValid = 1; OutReady = 0; tick(); InValid = 0;
`ifdef ENC_RANGE_CHECK_EN
        check("beq_range_flt", FLTo, 1);
        check("beq_range_nopush", OutValid, 0);
`else
        check("beq_trunc_valid", OutValid, 1);
        check("beq_trunc_instr", Instr, 16'h2000);
`endif
        OutReady = 1; tick();

        // Randomized traffic with occasional org loads and mid-run resets
        for (int n = 0; n < 3000; n++) begin
            rand_fields();
            InValid  = ($urandom_range(0, 3) != 0);
            OutReady = ((n / 64) % 3 == 1) ? ($urandom_range(0, 7) == 0) : 1'($urandom);
            OrgValid = ($urandom_range(0, 15) == 0);
            OrgAddr  = $urandom_range(0, 1) ? 16'($urandom) : 16'(16'hFFF8 + $urandom_range(0, 7));
            if (n % 997 == 500) begin
                InValid = 0; OrgValid = 0;
                do_reset();
            end else begin
                tick();
            end
        end

        clear_inputs();
        OutReady = 1;
        for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) tick();
        check("final_empty", OutValid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
